spi_peripheral: RTL

Oversampled SPI responder (mode 0: CPOL=0, CPHA=0, MSB first) for the spi_controller_interface area: the far end of the SPI controller's link, used as the device-side model in the controller's loopback benches and as a real target in FPGA designs. The block synchronises the external sclk/cs_n/mosi into the system clock domain, deserialises received words into a parallel strobe, and serialises a word from a one-deep transmit holding register onto miso. All logic runs on the single system clock; sclk is treated as data, never as a clock.

---
 rtl/spi_peripheral_pkg.sv | 16 +
 rtl/sync_ff.sv | 24 ++
 rtl/spi_peripheral.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_peripheral_pkg.sv
// Shared types and defaults for the mode-0 oversampled SPI responder.
package spi_peripheral_pkg;

    typedef enum logic {
        StIdle,
        StActive
    } state_t;

    localparam int unsigned DefaultWidth      = 8;
    localparam int unsigned DefaultSyncStages = 2;

    // Only mode 0 is implemented: sclk idles low, sample on rise, shift on fall.
    localparam bit Cpol = 1'b0;
    localparam bit Cpha = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit, with a per-instance reset value.
module sync_ff #(
    parameter int unsigned DEPTH       = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stages;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stages <= {DEPTH{RESET_VALUE}};
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI responder running entirely on the system clock; sclk is sampled as data.
// Receives words into rx_data and transmits from a one-deep holding register on miso.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int unsigned WIDTH       = DefaultWidth,
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    logic sclk_s, cs_n_s, mosi_s, sclk_d;
    logic rise, fall;

    state_t state_q, state_d;

    logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             miso_q, miso_d;
    logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             underrun_q, underrun_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic enter, leave, run, word_load, shift_fall, take_rise, handshake;
    logic [WIDTH-1:0] rx_next;

    sync_ff #(
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sync_sclk (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (sclk),
        .q       (sclk_s)
    );

    sync_ff #(
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE (1'b1)
    ) u_sync_cs_n (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (cs_n),
        .q       (cs_n_s)
    );

    sync_ff #(
        .DEPTH       (SYNC_STAGES),
        .RESET_VALUE (1'b0)
    ) u_sync_mosi (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (mosi),
        .q       (mosi_s)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    assign rise = sclk_s & ~sclk_d;
    assign fall = ~sclk_s & sclk_d;

    // FSM: state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (!cs_n_s) state_d = StActive;
            StActive: if (cs_n_s)  state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy    = 1'b0;
        miso_oe = 1'b0;
        if (state_q == StActive) begin
            busy    = 1'b1;
            miso_oe = 1'b1;
        end
    end

    assign enter      = (state_q == StIdle) && !cs_n_s;
    assign leave      = (state_q == StActive) && cs_n_s;
    assign run        = (state_q == StActive) && !cs_n_s;
    // With CPOL=0 the first edge of a word is a rise, so a fall seen at count 0
    // can only be the one that follows the previous word's last rise.
    assign word_load  = enter || (run && fall && (cnt_q == '0));
    assign shift_fall = run && fall && (cnt_q != '0);
    assign take_rise  = run && rise;
    assign handshake  = tx_valid && !hold_full_q;
    assign rx_next    = {rx_shift_q[WIDTH-2:0], mosi_s};

    always_comb begin
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        miso_d      = miso_q;
        rx_shift_d  = rx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        cnt_d       = cnt_q;

        if (word_load) begin
            hold_full_d = 1'b0;
            if (hold_full_q) begin
                tx_shift_d = hold_q;
                miso_d     = hold_q[WIDTH-1];
            end else begin
                tx_shift_d = '0;
                miso_d     = 1'b0;
                underrun_d = 1'b1;
            end
        end else if (shift_fall) begin
            tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
            miso_d     = tx_shift_q[WIDTH-2];
        end

        // Evaluated after the load so a same-cycle handshake lands in the now-empty holding slot.
        if (handshake) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        if (take_rise) begin
            rx_shift_d = rx_next;
            if (cnt_q == LastBit) begin
                cnt_d      = '0;
                rx_data_d  = rx_next;
                rx_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        if (leave) begin
            cnt_d      = '0;
            rx_shift_d = '0;
            miso_d     = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            miso_q      <= miso_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            cnt_q       <= cnt_d;
        end
    end

    assign miso        = miso_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_ready    = !hold_full_q;
    assign tx_underrun = underrun_q;

endmodule
